remote_btn_conditioner: RTL

Conditions the five player-2 button levels that arrive over the PMOD cable from the slave board, once the master/slave routing stage has steered them out of the JA pins. Each bit is double-flop synchronised, debounced with a per-button stability counter, and turned into a clean level plus one-cycle press and release pulses for the game FSM. When the board is a slave, all outputs are held idle.

---
 rtl/remote_btn_conditioner.sv | 111 +++++++++++
 1 files changed

// File: rtl/remote_btn_conditioner.sv
// Synchroniser, debouncer and press/release pulse generator for the five remote player-2 buttons.
// Optional auto-repeat on held buttons is built when REMOTE_BTN_REPEAT_EN is defined.
module remote_btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned CNT_W           = 17,
   parameter int unsigned REPEAT_DELAY    = 30000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       is_master,
   input  logic [4:0] btn_raw,
   output logic [4:0] btn_level,
   output logic [4:0] btn_press,
   output logic [4:0] btn_release
);

   localparam int unsigned NB = 5;
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES >> CNT_W) != 0 ||
       REPEAT_PERIOD > REPEAT_DELAY || REPEAT_PERIOD == 0) begin : g_bad_params
      $error("remote_btn_conditioner: inconsistent parameters");
   end

   logic [4:0]       sync1_q, sync2_q;
   logic [4:0]       level_q, level_d;
   logic [4:0]       press_q, press_d;
   logic [4:0]       release_q, release_d;
   logic [CNT_W-1:0] cnt_q [NB];
   logic [CNT_W-1:0] cnt_d [NB];

`ifdef REMOTE_BTN_REPEAT_EN
   localparam int unsigned RCNT_W = $clog2(REPEAT_DELAY);
   localparam logic [RCNT_W-1:0] RcntFire   = RCNT_W'(REPEAT_DELAY - 1);
   // Reloading here makes the next fire land exactly REPEAT_PERIOD cycles later.
   localparam logic [RCNT_W-1:0] RcntReload = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [RCNT_W-1:0] rcnt_q [NB];
   logic [RCNT_W-1:0] rcnt_d [NB];
`endif

   always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
`ifdef REMOTE_BTN_REPEAT_EN
      rcnt_d    = rcnt_q;
`endif
      for (int i = 0; i < NB; i++) begin
         if (!is_master) begin
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
         end else if (sync2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            level_d[i]   = sync2_q[i];
            cnt_d[i]     = '0;
            press_d[i]   = sync2_q[i];
            release_d[i] = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
`ifdef REMOTE_BTN_REPEAT_EN
         rcnt_d[i] = '0;
         if (is_master && level_q[i] && level_d[i]) begin
            if (rcnt_q[i] == RcntFire) begin
               press_d[i] = 1'b1;
               rcnt_d[i]  = RcntReload;
            end else begin
               rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= '0;
`ifdef REMOTE_BTN_REPEAT_EN
            rcnt_q[i] <= '0;
`endif
         end
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= cnt_d[i];
`ifdef REMOTE_BTN_REPEAT_EN
            rcnt_q[i] <= rcnt_d[i];
`endif
         end
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule
